// File: rtl/ray_pkg.sv
// Shared definitions for the primary-ray generator: default widths, the FSM state type
// and the word layout of a ray as presented to the ray FIFO.
package ray_pkg;

  localparam int D_BITS_DEF = 32;
  localparam int Q_BITS_DEF = 10;
  localparam int ONE_Q      = 1 << Q_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } gen_state_t;

  localparam int RAY_OX = 0;
  localparam int RAY_OY = 1;
  localparam int RAY_OZ = 2;
  localparam int RAY_DX = 3;
  localparam int RAY_DY = 4;
  localparam int RAY_DZ = 5;

endpackage

// File: rtl/ray_dir_calc.sv
// Combinational primary-ray direction for one pixel: centred integer pixel offsets
// scaled by the fixed-point pixel pitch, with the focal distance as the z component.
module ray_dir_calc
  import ray_pkg::*;
#(
  parameter int D_BITS = D_BITS_DEF,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int X_BITS = $clog2(IMG_W),
  parameter int Y_BITS = $clog2(IMG_H)
) (
  input  logic [X_BITS-1:0]      x,
  input  logic [Y_BITS-1:0]      y,
  input  logic [D_BITS-1:0]      pix_step,
  input  logic [D_BITS-1:0]      focal,
  output logic [2:0][D_BITS-1:0] dir
);

  logic signed [D_BITS-1:0] off_x;
  logic signed [D_BITS-1:0] off_y;
  logic signed [D_BITS-1:0] prod_x;
  logic signed [D_BITS-1:0] prod_y;

  // Offsets are plain integers, so int * Q-value is already in Q format; only the
  // low D_BITS of the product are kept, which a D_BITS-wide signed multiply yields.
  always_comb begin
    off_x  = $signed(D_BITS'(x)) - $signed(D_BITS'(IMG_W / 2));
    off_y  = $signed(D_BITS'(IMG_H / 2)) - $signed(D_BITS'(y));
    prod_x = off_x * $signed(pix_step);
    prod_y = off_y * $signed(pix_step);
    dir[0] = prod_x;
    dir[1] = prod_y;
    dir[2] = focal;
  end

endmodule

// File: rtl/ray_generator.sv
// Camera-side ray source: walks the image in raster order and writes one primary ray
// per pixel into the downstream ray FIFO, stalling whenever the FIFO reports full.
module ray_generator
  import ray_pkg::*;
#(
  parameter int D_BITS = D_BITS_DEF,
  parameter int Q_BITS = Q_BITS_DEF,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  localparam int X_BITS = $clog2(IMG_W),
  localparam int Y_BITS = $clog2(IMG_H)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0][D_BITS-1:0] cam_origin,
  input  logic [D_BITS-1:0]      pix_step,
  input  logic [D_BITS-1:0]      focal,
  input  logic                   out_full,
  output logic                   out_wr_en,
  output logic [5:0][D_BITS-1:0] ray_out,
  output logic [X_BITS-1:0]      pixel_x,
  output logic [Y_BITS-1:0]      pixel_y,
  output logic                   busy,
  output logic                   done
);

  if (Q_BITS >= D_BITS || IMG_W < 2 || IMG_H < 2 || (IMG_W % 2) != 0 || (IMG_H % 2) != 0)
  begin : g_bad_params
    $error("ray_generator: unsupported parameter combination");
  end

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_H - 1);

  gen_state_t               state;
  logic [X_BITS-1:0]        x;
  logic [Y_BITS-1:0]        y;
  logic [2:0][D_BITS-1:0]   origin_q;
  logic [D_BITS-1:0]        step_q;
  logic [D_BITS-1:0]        focal_q;
  logic [2:0][D_BITS-1:0]   dir;

  assign out_wr_en = (state == EMIT) && !out_full;
  assign busy      = (state == EMIT);
  assign done      = (state == DONE);

  // Counters move only on an actual write, so backpressure can never skip or repeat a pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      origin_q <= '0;
      step_q   <= '0;
      focal_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            origin_q <= cam_origin;
            step_q   <= pix_step;
            focal_q  <= focal;
            x        <= '0;
            y        <= '0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (out_wr_en) begin
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                y     <= '0;
                state <= DONE;
              end else begin
                y <= y + Y_BITS'(1);
              end
            end else begin
              x <= x + X_BITS'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ray_dir_calc #(
    .D_BITS (D_BITS),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_dir (
    .x        (x),
    .y        (y),
    .pix_step (step_q),
    .focal    (focal_q),
    .dir      (dir)
  );

  assign ray_out[RAY_OX] = origin_q[0];
  assign ray_out[RAY_OY] = origin_q[1];
  assign ray_out[RAY_OZ] = origin_q[2];
  assign ray_out[RAY_DX] = dir[0];
  assign ray_out[RAY_DY] = dir[1];
  assign ray_out[RAY_DZ] = dir[2];
  assign pixel_x         = x;
  assign pixel_y         = y;

endmodule

// File: tb/tb_ray_generator.sv
// Scoreboard bench for ray_generator: a 2x2 instance for directed frame scenarios and a
// 64x64 instance for a full frame under random backpressure.
module tb_ray_generator;

  typedef struct packed {
    int               x;
    int               y;
    logic [5:0][31:0] ray;
  } exp_t;

  logic             clock;
  logic             reset;

  logic             start_s, full_s, wr_s, busy_s, done_s;
  logic [2:0][31:0] org_s;
  logic [31:0]      step_s, focal_s;
  logic [5:0][31:0] ray_s;
  logic [0:0]       px_s, py_s;

  logic             start_b, full_b, wr_b, busy_b, done_b;
  logic [2:0][31:0] org_b;
  logic [31:0]      step_b, focal_b;
  logic [5:0][31:0] ray_b;
  logic [5:0]       px_b, py_b;

  exp_t sq[$];
  exp_t bq[$];
  exp_t es, eb;
  int   compared   = 0;
  int   mismatched = 0;
  int   writes_s   = 0;
  int   writes_b   = 0;
  int   done_cnt_s = 0;

  ray_generator #(.D_BITS(32), .Q_BITS(10), .IMG_W(2), .IMG_H(2)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .cam_origin(org_s), .pix_step(step_s),
    .focal(focal_s), .out_full(full_s), .out_wr_en(wr_s), .ray_out(ray_s),
    .pixel_x(px_s), .pixel_y(py_s), .busy(busy_s), .done(done_s)
  );

  ray_generator #(.D_BITS(32), .Q_BITS(10), .IMG_W(64), .IMG_H(64)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .cam_origin(org_b), .pix_step(step_b),
    .focal(focal_b), .out_full(full_b), .out_wr_en(wr_b), .ray_out(ray_b),
    .pixel_x(px_b), .pixel_y(py_b), .busy(busy_b), .done(done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected rays for a whole frame, built from the pixel grid and the camera inputs.
  task automatic push_frame(input bit big, input int w, input int h,
                            input logic [2:0][31:0] org, input logic [31:0] step,
                            input logic [31:0] foc);
    exp_t e;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        e.x      = xx;
        e.y      = yy;
        e.ray[0] = org[0];
        e.ray[1] = org[1];
        e.ray[2] = org[2];
        e.ray[3] = 32'((xx - w / 2) * $signed(step));
        e.ray[4] = 32'((h / 2 - yy) * $signed(step));
        e.ray[5] = foc;
        if (big) bq.push_back(e);
        else     sq.push_back(e);
      end
    end
  endtask

  task automatic apply_stimulus_start_s();
    @(posedge clock); #1 start_s = 1'b1;
    @(posedge clock); #1 start_s = 1'b0;
  endtask

  task automatic wait_done_s(input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clock);
      if (done_s === 1'b1) break;
      cycles++;
    end
    check_output("s_done_seen", 32'(done_s), 32'd1);
  endtask

  // Scoreboard pop for the 2x2 instance: every write must match the next expected ray.
  always @(negedge clock) begin
    if (wr_s === 1'b1) begin
      writes_s++;
      if (sq.size() == 0) begin
        check_output("s_unexpected_write", 32'(sq.size()), 32'd1);
      end else begin
        es = sq.pop_front();
        check_output("s_pixel_x", 32'(px_s), 32'(es.x));
        check_output("s_pixel_y", 32'(py_s), 32'(es.y));
        for (int k = 0; k < 6; k++) check_output($sformatf("s_ray%0d", k), ray_s[k], es.ray[k]);
      end
    end
    if (done_s === 1'b1) done_cnt_s++;
  end

  always @(negedge clock) begin
    if (wr_b === 1'b1) begin
      writes_b++;
      if (bq.size() == 0) begin
        check_output("b_unexpected_write", 32'(bq.size()), 32'd1);
      end else begin
        eb = bq.pop_front();
        check_output("b_pixel_x", 32'(px_b), 32'(eb.x));
        check_output("b_pixel_y", 32'(py_b), 32'(eb.y));
        for (int k = 0; k < 6; k++) check_output($sformatf("b_ray%0d", k), ray_b[k], eb.ray[k]);
      end
    end
  end

  initial begin
    int n, w0, d0;
    reset   = 1'b0;
    start_s = 1'b0; full_s = 1'b0; org_s = '0; step_s = '0; focal_s = '0;
    start_b = 1'b0; full_b = 1'b0; org_b = '0; step_b = '0; focal_b = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_output("rst_wr_en", 32'(wr_s), 32'd0);
    check_output("rst_busy", 32'(busy_s), 32'd0);
    check_output("rst_done", 32'(done_s), 32'd0);
    check_output("rst_pixel_x", 32'(px_s), 32'd0);
    check_output("rst_pixel_y", 32'(py_s), 32'd0);
    for (int k = 0; k < 6; k++) check_output($sformatf("rst_ray%0d", k), ray_s[k], 32'd0);
    check_output("rst_b_busy", 32'(busy_b), 32'd0);
    #2 reset = 1'b1;

    // Frame 1: no backpressure, 4 consecutive writes then one done pulse
    org_s[0] = 32'd0; org_s[1] = 32'd0; org_s[2] = -32'sd5120;
    step_s = 32'd1024; focal_s = 32'd1024;
    push_frame(1'b0, 2, 2, org_s, step_s, focal_s);
    w0 = writes_s; d0 = done_cnt_s;
    apply_stimulus_start_s();
    wait_done_s(20, n);
    check_output("f1_cycles_to_done", 32'(n), 32'd4);
    @(negedge clock);
    check_output("f1_done_width", 32'(done_s), 32'd0);
    check_output("f1_busy_after", 32'(busy_s), 32'd0);
    check_output("f1_writes", 32'(writes_s - w0), 32'd4);
    check_output("f1_done_pulses", 32'(done_cnt_s - d0), 32'd1);
    check_output("f1_queue_empty", 32'(sq.size()), 32'd0);

    // Frame 2: stall 3 cycles after 2nd write; restart and origin change during EMIT
    push_frame(1'b0, 2, 2, org_s, step_s, focal_s);
    w0 = writes_s; d0 = done_cnt_s;
    apply_stimulus_start_s();
    @(posedge clock);
    @(posedge clock);
    #1 full_s = 1'b1; start_s = 1'b1; org_s[0] = 32'd77;
    repeat (3) begin
      @(negedge clock);
      check_output("f2_stall_wr_en", 32'(wr_s), 32'd0);
      check_output("f2_stall_px", 32'(px_s), 32'd0);
      check_output("f2_stall_py", 32'(py_s), 32'd1);
      check_output("f2_stall_busy", 32'(busy_s), 32'd1);
    end
    @(posedge clock); #1 full_s = 1'b0; start_s = 1'b0;
    wait_done_s(20, n);
    check_output("f2_cycles_after_release", 32'(n), 32'd2);
    @(negedge clock);
    check_output("f2_writes", 32'(writes_s - w0), 32'd4);
    check_output("f2_done_pulses", 32'(done_cnt_s - d0), 32'd1);
    check_output("f2_queue_empty", 32'(sq.size()), 32'd0);
    org_s[0] = 32'd0;

    // Frame 3: reset mid-frame, then a clean restart from pixel (0,0)
    push_frame(1'b0, 2, 2, org_s, step_s, focal_s);
    d0 = done_cnt_s;
    apply_stimulus_start_s();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check_output("f3_rst_wr_en", 32'(wr_s), 32'd0);
    check_output("f3_rst_busy", 32'(busy_s), 32'd0);
    check_output("f3_rst_px", 32'(px_s), 32'd0);
    check_output("f3_rst_py", 32'(py_s), 32'd0);
    for (int k = 0; k < 6; k++) check_output($sformatf("f3_rst_ray%0d", k), ray_s[k], 32'd0);
    sq.delete();
    repeat (3) @(negedge clock);
    check_output("f3_no_done", 32'(done_cnt_s - d0), 32'd0);
    #2 reset = 1'b1;
    push_frame(1'b0, 2, 2, org_s, step_s, focal_s);
    w0 = writes_s;
    apply_stimulus_start_s();
    wait_done_s(20, n);
    @(negedge clock);
    check_output("f3_restart_writes", 32'(writes_s - w0), 32'd4);
    check_output("f3_queue_empty", 32'(sq.size()), 32'd0);

    // Frame 4: 64x64, negative pitch, random 50% backpressure
    org_b[0] = 32'd100; org_b[1] = -32'sd200; org_b[2] = 32'd300;
    step_b = -32'sd16; focal_b = 32'd2048;
    push_frame(1'b1, 64, 64, org_b, step_b, focal_b);
    w0 = writes_b;
    @(posedge clock); #1 start_b = 1'b1;
    @(posedge clock); #1 start_b = 1'b0;
    check_output("f4_first_dir_x", ray_b[3], 32'd512);
    check_output("f4_first_wr_en", 32'(wr_b), 32'd1);
    n = 0;
    while (n < 20000 && done_b !== 1'b1) begin
      @(posedge clock); #1;
      full_b = 1'($urandom_range(0, 1));
      n++;
    end
    full_b = 1'b0;
    check_output("f4_done_seen", 32'(done_b), 32'd1);
    check_output("f4_writes", 32'(writes_b - w0), 32'd4096);
    check_output("f4_queue_empty", 32'(bq.size()), 32'd0);

    // Frame 5: FIFO full from the start, pixel (0,0) held
    full_s = 1'b1;
    w0 = writes_s;
    apply_stimulus_start_s();
    repeat (10) @(negedge clock);
    check_output("f5_busy", 32'(busy_s), 32'd1);
    check_output("f5_wr_en", 32'(wr_s), 32'd0);
    check_output("f5_px", 32'(px_s), 32'd0);
    check_output("f5_py", 32'(py_s), 32'd0);
    check_output("f5_writes", 32'(writes_s - w0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
